// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and sizing.
package regfile_dump_reader_pkg;

  localparam int N_DEFAULT = 32;
  localparam int REG_COUNT = 32;
  localparam int IDX_W     = $clog2(REG_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/regdump_out_stage.sv
// Output holding register for one dump beat; loads on i_load, otherwise holds.
module regdump_out_stage
  import regfile_dump_reader_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N-1:0]     d_data,
  input  logic [IDX_W-1:0] d_idx,
  input  logic             d_last,
  output logic [N-1:0]     q_data,
  output logic [IDX_W-1:0] q_idx,
  output logic             q_last
);

  logic [N-1:0]     r_data;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (load) begin
      r_data <= d_data;
      r_idx  <= d_idx;
      r_last <= d_last;
    end
  end

  assign q_data = r_data;
  assign q_idx  = r_idx;
  assign q_last = r_last;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register-file read port from first_reg to last_reg and streams each value out.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] first_reg,
  input  logic [IDX_W-1:0] last_reg,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [N-1:0]     rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           r_state;
  state_e           w_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_last_idx;
  logic             r_err;
  logic             w_load;
  logic             w_start_ok;
  logic             w_start_bad;

  assign w_start_ok  = start && (first_reg <= last_reg);
  assign w_start_bad = start && (first_reg > last_reg);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Termination is by equality with the latched last index, so last_reg=31 never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && w_start_bad;
      if ((r_state == IDLE) && w_start_ok) begin
        r_cnt      <= first_reg;
        r_last_idx <= last_reg;
      end else if ((r_state == SEND) && out_ready && !out_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      IDLE:  if (w_start_ok) w_next = FETCH;
      FETCH: begin
        w_load = 1'b1;
        w_next = SEND;
      end
      SEND:  if (out_ready) w_next = out_last ? DONE : FETCH;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign rd_addr   = (r_state == FETCH) ? r_cnt : '0;
  assign out_valid = (r_state == SEND);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;

  regdump_out_stage #(.N(N)) u_out_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .d_data (rd_data),
    .d_idx  (r_cnt),
    .d_last (r_cnt == r_last_idx),
    .q_data (out_data),
    .q_idx  (out_idx),
    .q_last (out_last)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: directed dumps, back-pressure, reject and reset cases.
module tb_regfile_dump_reader;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] regs [32];
  beat_t       sb [$];
  int          accept_cyc [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_err   = 0;
  int          cyc     = 0;

  bit          exp_done  = 1'b0;
  bit          hold_seen = 1'b0;
  beat_t       held;

  regfile_dump_reader #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold stability and done timing.
  always @(negedge clk) begin
    if (rst) begin
      hold_seen = 1'b0;
      exp_done  = 1'b0;
    end else begin
      if (err) n_err++;
      if (exp_done) begin
        check("done_after_last", 32'(done), 32'd1);
        exp_done = 1'b0;
      end else if (done) begin
        check("unexpected_done", 32'(done), 32'd0);
      end
      if (hold_seen) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, held.data);
        check("hold_idx", 32'(out_idx), 32'(held.idx));
        check("hold_last", 32'(out_last), 32'(held.last));
        hold_seen = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_idx", 32'(out_idx), 32'(e.idx));
          check("beat_data", out_data, e.data);
          check("beat_last", 32'(out_last), 32'(e.last));
          accept_cyc.push_back(cyc);
          if (out_last) exp_done = 1'b1;
        end
      end else if (out_valid) begin
        hold_seen = 1'b1;
        held.idx  = out_idx;
        held.data = out_data;
        held.last = out_last;
      end
    end
  end

  task automatic expect_beat(input logic [4:0] idx, input logic [31:0] data, input logic last);
    beat_t b;
    b.idx  = idx;
    b.data = data;
    b.last = last;
    sb.push_back(b);
  endtask

  // Presents start for exactly one cycle; returns #1 after the sampling edge.
  task automatic drive_start(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    first_reg = f;
    last_reg  = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, 32'(idle), 32'd1);
    @(negedge clk);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Dump x1..x3 with ready held high
    regs[1] = 32'h11;
    regs[2] = 32'h22;
    regs[3] = 32'h33;
    out_ready = 1'b1;
    accept_cyc.delete();
    expect_beat(5'd1, 32'h11, 1'b0);
    expect_beat(5'd2, 32'h22, 1'b0);
    expect_beat(5'd3, 32'h33, 1'b1);
    drive_start(5'd1, 5'd3);
    @(negedge clk);
    check("t1_fetch_busy", 32'(busy), 32'd1);
    check("t1_fetch_rd_addr", 32'(rd_addr), 32'd1);
    check("t1_fetch_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_first_valid", 32'(out_valid), 32'd1);
    wait_idle("t1");
    check("t1_beats", 32'(accept_cyc.size()), 32'd3);
    if (accept_cyc.size() == 3) begin
      check("t1_gap_a", 32'(accept_cyc[1] - accept_cyc[0]), 32'd2);
      check("t1_gap_b", 32'(accept_cyc[2] - accept_cyc[1]), 32'd2);
    end

    // Single-register dump
    regs[5] = 32'hDEADBEEF;
    expect_beat(5'd5, 32'hDEADBEEF, 1'b1);
    drive_start(5'd5, 5'd5);
    wait_idle("t2");

    // Top of range with back-pressure; a start while busy must be ignored
    regs[30]  = 32'hA5A5_0030;
    regs[31]  = 32'h5A5A_0031;
    out_ready = 1'b0;
    expect_beat(5'd30, 32'hA5A5_0030, 1'b0);
    expect_beat(5'd31, 32'h5A5A_0031, 1'b1);
    drive_start(5'd30, 5'd31);
    @(negedge clk);
    @(negedge clk);
    check("t3_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start     = (i == 1);
      first_reg = 5'd0;
      last_reg  = 5'd0;
    end
    out_ready = 1'b1;
    wait_idle("t3");
    check("t3_no_err", 32'(n_err), 32'd0);

    // Rejected request: first > last
    drive_start(5'd7, 5'd3);
    @(negedge clk);
    check("t4_err_pulse", 32'(err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_err_clear", 32'(err), 32'd0);
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_err_count", 32'(n_err), 32'd1);

    // Reset during SEND of a full dump, then a one-beat dump of x0
    for (int i = 1; i < 32; i++) regs[i] = 32'h100 + 32'(i);
    regs[0]   = 32'h0;
    out_ready = 1'b0;
    drive_start(5'd0, 5'd31);
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_pre_rst", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_idx", 32'(out_idx), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    first_reg = 5'd0;
    last_reg  = 5'd0;
    expect_beat(5'd0, 32'h0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t5_restart_busy", 32'(busy), 32'd1);
    wait_idle("t5");
    check("final_err_count", 32'(n_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning register data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a dump; sampled only in IDLE.
REQ-005 The block SHALL have port first_reg, input, 5, index of the first register to dump; sampled with start.
REQ-006 The block SHALL have port last_reg, input, 5, index of the last register to dump; sampled with start.
REQ-007 The block SHALL have port rd_addr, output, 5, address driven to one register-file read port.
REQ-008 The block SHALL have port rd_data, input, N, combinational read data returned for rd_addr in the same cycle.
REQ-009 The block SHALL have port out_valid, output, 1, out_data/out_idx/out_last hold a valid beat.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the beat when high together with out_valid.
REQ-011 The block SHALL have port out_data, output, N, captured register value.
REQ-012 The block SHALL have port out_idx, output, 5, register index of out_data.
REQ-013 The block SHALL have port out_last, output, 1, marks the final beat of the dump.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse after the final beat is accepted.
REQ-016 The block SHALL have port err, output, 1, one-cycle pulse when start is rejected.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, SEND, DONE.
REQ-018 In IDLE, start=1 with first_reg<=last_reg SHALL load the 5-bit counter with first_reg, latch last_reg and move to FETCH next cycle.
REQ-019 In IDLE, start=1 with first_reg>last_reg SHALL assert err for exactly the next cycle and remain in IDLE.
REQ-020 rd_addr SHALL equal the counter in FETCH and 0 in all other states.
REQ-021 In FETCH, out_data<=rd_data, out_idx<=counter, out_last<=(counter==latched last), then move to SEND.
REQ-022 In SEND, out_valid SHALL be 1, and out_data/out_idx/out_last SHALL stay stable until out_ready=1.
REQ-023 In SEND with out_ready=1: if out_last then move to DONE, else increment the counter and move to FETCH.
REQ-024 In DONE, done SHALL be 1 for that cycle only, then the FSM returns to IDLE.
REQ-025 The first beat SHALL be valid 2 cycles after the start cycle; steady-state throughput SHALL be one beat per 2 cycles with out_ready held high.
REQ-026 Termination SHALL rely on equality with the latched last index; last_reg=31 SHALL end without counter wrap.
REQ-027 A first_reg==last_reg request SHALL produce exactly one beat with out_last=1.
REQ-028 start, first_reg and last_reg SHALL be ignored while busy=1.
REQ-029 Index 0 SHALL be dumped like any other index, carrying whatever rd_data returns (0 for x0).

Reset
REQ-030 rst=1 SHALL force IDLE and clear the counter, out_valid, out_data, out_idx, out_last, done and err to 0 at the next edge.
REQ-031 Reset asserted mid-dump SHALL abandon the dump with no done pulse; a new start SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, N default 32 and REG_COUNT=32.
REQ-033 The output holding register (out_data/out_idx/out_last with load enable) SHALL be one sub-module named regdump_out_stage; the FSM and counter remain in the top module.

Verification
REQ-034 Preload x1..x3 with 0x11, 0x22, 0x33; start with first=1, last=3, out_ready=1 -> beats (1,0x11), (2,0x22), (3,0x33,last), then done one cycle later.
REQ-035 first=5, last=5, x5=0xDEADBEEF -> a single beat idx 5 with out_last=1, then done.
REQ-036 first=30, last=31, out_ready low 4 cycles on beat 30 -> beat held stable, then idx 31 with last; counter does not wrap.
REQ-037 first=7, last=3 -> one-cycle err pulse, busy stays 0, no beats.
REQ-038 rst pulse during SEND of a 0..31 dump -> out_valid 0 next cycle, no done; new start first=0, last=0 -> one beat idx 0, data 0.
